// File: rtl/burst_ram_if.sv
// BurstRAM-style port: one command with address and first write beat,
// then the rest of the burst; busy gates acceptance of a held request.
interface burst_ram_if #(
  parameter int AW = 4
);
  logic          cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic [63:0]   wr_data;
  logic [7:0]    data_mask;
  logic [63:0]   rd_data;
  logic          rd_data_ready;
  logic          busy;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_ready, busy
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_ready, busy
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-client round-robin burst arbiter in front of one BurstRAM.
// Whole bursts are granted; read beats steer only to the owner.
module burst_ram_arbiter #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT    = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  burst_ram_if.slave  c0,
  burst_ram_if.slave  c1,
  burst_ram_if.master br,
  output logic       owner,
  output logic       active
);

  localparam int CW = $clog2(BURST_COUNT) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  localparam logic [CW-1:0] LAST_WR = CW'(BURST_COUNT - 1);
  localparam logic [CW-1:0] LAST_RD = CW'(BURST_COUNT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          live_q, live_d;

  logic idle;
  logic can_arb;
  logic grant;
  logic win;
  logic sel;
  logic win_cmd;
  logic rd_beat;

  always_comb begin
    idle    = (state_q == IDLE);
    can_arb = live_q & ~br.busy & idle;
    grant   = can_arb & (c0.cmd_en | c1.cmd_en);
    win     = (c0.cmd_en & c1.cmd_en) ? ptr_q : c1.cmd_en;
    // Outside a grant the bus follows the owner so write beats route.
    sel     = grant ? win : owner_q;
    win_cmd = win ? c1.cmd : c0.cmd;
    rd_beat = live_q & (state_q == READ) & br.rd_data_ready;
  end

  always_comb begin
    br.cmd       = sel ? c1.cmd       : c0.cmd;
    br.addr      = sel ? c1.addr      : c0.addr;
    br.wr_data   = sel ? c1.wr_data   : c0.wr_data;
    br.data_mask = sel ? c1.data_mask : c0.data_mask;
    br.cmd_en    = grant;
  end

  always_comb begin
    c0.busy          = ~can_arb | (grant & win);
    c1.busy          = ~can_arb | (grant & ~win);
    c0.rd_data       = br.rd_data;
    c1.rd_data       = br.rd_data;
    c0.rd_data_ready = rd_beat & ~owner_q;
    c1.rd_data_ready = rd_beat & owner_q;
  end

  assign owner  = owner_q;
  assign active = ~idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    live_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = win;
          ptr_d   = ~win;
          cnt_d   = CW'(1);
          state_d = win_cmd ? WRITE : READ;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_WR) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        if (rd_beat) begin
          if (cnt_q == LAST_RD) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: reset, read/write bursts,
// round-robin fairness, br_busy stall and mid-burst reset.
module tb_burst_ram_arbiter;
  localparam int AW = 4;
  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic owner;
  logic active;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  burst_ram_if #(.AW(AW)) c0_if ();
  burst_ram_if #(.AW(AW)) c1_if ();
  burst_ram_if #(.AW(AW)) br_if ();

  burst_ram_arbiter #(
    .DEPTH_BITWIDTH(AW),
    .BURST_COUNT(BC)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .c0       (c0_if),
    .c1       (c1_if),
    .br       (br_if),
    .owner    (owner),
    .active   (active)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic busy2(input string tag, input logic b0, input logic b1);
    chk({tag, "_c0_busy"}, 64'(c0_if.busy), 64'(b0));
    chk({tag, "_c1_busy"}, 64'(c1_if.busy), 64'(b1));
  endtask

  task automatic rbeat(input string tag, input logic vld,
                       input logic [63:0] d, input logic e0,
                       input logic e1);
    br_if.rd_data_ready = vld;
    br_if.rd_data = d;
    #1;
    chk({tag, "_c0_rdy"}, 64'(c0_if.rd_data_ready), 64'(e0));
    chk({tag, "_c1_rdy"}, 64'(c1_if.rd_data_ready), 64'(e1));
    chk({tag, "_c0_data"}, c0_if.rd_data, d);
    chk({tag, "_c1_data"}, c1_if.rd_data, d);
    chk({tag, "_active"}, 64'(active), 64'd1);
    busy2(tag, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    c0_if.cmd = 1'b0; c0_if.cmd_en = 1'b1;
    c0_if.addr = 4'd3; c0_if.wr_data = '0;
    c0_if.data_mask = 8'hFF;
    c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b0;
    c1_if.addr = '0; c1_if.wr_data = '0;
    c1_if.data_mask = 8'h00;
    br_if.rd_data = '0; br_if.rd_data_ready = 1'b0;
    br_if.busy = 1'b0;

    // reset held
    tick();
    busy2("rst", 1'b1, 1'b1);
    chk("rst_cmd_en", 64'(br_if.cmd_en), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_rdy", 64'(c0_if.rd_data_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("live0_c0_busy", 64'(c0_if.busy), 64'd1);
    chk("live0_cmd_en", 64'(br_if.cmd_en), 64'd0);
    tick();
    chk("acc0_c0_busy", 64'(c0_if.busy), 64'd0);
    chk("acc0_cmd_en", 64'(br_if.cmd_en), 64'd1);
    chk("acc0_addr", 64'(br_if.addr), 64'd3);
    chk("acc0_cmd", 64'(br_if.cmd), 64'd0);

    // c0 read burst with a gap after beat 2
    tick();
    c0_if.cmd_en = 1'b0;
    chk("rd_owner", 64'(owner), 64'd0);
    rbeat("rd_b1", 1'b1, 64'h1111, 1'b1, 1'b0); tick();
    rbeat("rd_b2", 1'b1, 64'h2222, 1'b1, 1'b0); tick();
    rbeat("rd_gap", 1'b0, 64'h2222, 1'b0, 1'b0); tick();
    rbeat("rd_b3", 1'b1, 64'h3333, 1'b1, 1'b0); tick();
    rbeat("rd_b4", 1'b1, 64'h4444, 1'b1, 1'b0); tick();
    #1;
    chk("rd_done_active", 64'(active), 64'd0);
    chk("rd_idle_gate", 64'(c0_if.rd_data_ready), 64'd0);
    br_if.rd_data_ready = 1'b0;

    // c1 write burst
    c1_if.cmd = 1'b1; c1_if.cmd_en = 1'b1;
    c1_if.addr = 4'd5; c1_if.wr_data = 64'hA;
    c1_if.data_mask = 8'hF0;
    #1;
    chk("wr_cmd_en", 64'(br_if.cmd_en), 64'd1);
    chk("wr_cmd", 64'(br_if.cmd), 64'd1);
    chk("wr_addr", 64'(br_if.addr), 64'd5);
    chk("wr_A", br_if.wr_data, 64'hA);
    chk("wr_mask", 64'(br_if.data_mask), 64'hF0);
    chk("wr_c1_busy", 64'(c1_if.busy), 64'd0);
    tick();
    c1_if.cmd_en = 1'b0; c1_if.wr_data = 64'hB;
    br_if.rd_data_ready = 1'b1;
    #1;
    chk("wr_B", br_if.wr_data, 64'hB);
    chk("wr_b2_cmd_en", 64'(br_if.cmd_en), 64'd0);
    chk("wr_owner", 64'(owner), 64'd1);
    chk("wr_rdy_gate", 64'(c1_if.rd_data_ready), 64'd0);
    busy2("wr_b2", 1'b1, 1'b1);
    tick();
    c1_if.wr_data = 64'hC;
    #1;
    chk("wr_C", br_if.wr_data, 64'hC);
    busy2("wr_b3", 1'b1, 1'b1);
    tick();
    c1_if.wr_data = 64'hD;
    #1;
    chk("wr_D", br_if.wr_data, 64'hD);
    chk("wr_D_mask", 64'(br_if.data_mask), 64'hF0);
    busy2("wr_b4", 1'b1, 1'b1);
    tick();
    br_if.rd_data_ready = 1'b0;
    #1;
    chk("wr_done_active", 64'(active), 64'd0);
    busy2("wr_idle", 1'b0, 1'b0);

    // simultaneous requests alternate c0,c1,c0,c1
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = 1'(i % 2);
      c0_if.cmd = 1'b1; c0_if.cmd_en = 1'b1; c0_if.addr = 4'd1;
      c1_if.cmd = 1'b1; c1_if.cmd_en = 1'b1; c1_if.addr = 4'd2;
      #1;
      chk("rr_cmd_en", 64'(br_if.cmd_en), 64'd1);
      chk("rr_addr", 64'(br_if.addr), w ? 64'd2 : 64'd1);
      busy2("rr_grant", w, ~w);
      tick();
      if (w) c1_if.cmd_en = 1'b0;
      else c0_if.cmd_en = 1'b0;
      chk("rr_owner", 64'(owner), 64'(w));
      for (int j = 0; j < BC - 1; j++) begin
        #1;
        busy2("rr_burst", 1'b1, 1'b1);
        tick();
      end
    end
    c0_if.cmd_en = 1'b0; c1_if.cmd_en = 1'b0;

    // br_busy stall with both requesting
    br_if.busy = 1'b1;
    c0_if.cmd_en = 1'b1; c1_if.cmd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_cmd_en", 64'(br_if.cmd_en), 64'd0);
      busy2("stall", 1'b1, 1'b1);
      tick();
    end
    br_if.busy = 1'b0;
    #1;
    chk("unstall_cmd_en", 64'(br_if.cmd_en), 64'd1);
    chk("unstall_addr", 64'(br_if.addr), 64'd1);
    busy2("unstall", 1'b0, 1'b1);
    tick();
    c0_if.cmd_en = 1'b0; c1_if.cmd_en = 1'b0;
    repeat (BC - 1) tick();
    chk("unstall_done", 64'(active), 64'd0);

    // reset pulsed during c1 read beat 2
    c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b1; c1_if.addr = 4'd7;
    #1;
    chk("mr_addr", 64'(br_if.addr), 64'd7);
    tick();
    c1_if.cmd_en = 1'b0;
    rbeat("mr_b1", 1'b1, 64'h5555, 1'b0, 1'b1); tick();
    rbeat("mr_b2", 1'b1, 64'h6666, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_active", 64'(active), 64'd0);
    chk("mr_owner", 64'(owner), 64'd0);
    chk("mr_rdy", 64'(c1_if.rd_data_ready), 64'd0);
    busy2("mr_rst", 1'b1, 1'b1);
    br_if.rd_data_ready = 1'b0;
    c0_if.cmd = 1'b0; c0_if.cmd_en = 1'b1; c0_if.addr = 4'd1;
    c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b1; c1_if.addr = 4'd2;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_live0_cmd_en", 64'(br_if.cmd_en), 64'd0);
    busy2("mr_live0", 1'b1, 1'b1);
    tick();
    chk("mr_grant_cmd_en", 64'(br_if.cmd_en), 64'd1);
    chk("mr_grant_addr", 64'(br_if.addr), 64'd1);
    busy2("mr_grant", 1'b0, 1'b1);
    tick();
    c0_if.cmd_en = 1'b0; c1_if.cmd_en = 1'b0;
    chk("mr_owner_after", 64'(owner), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
